seq_multiplier: RTL and testbench

- Iterative shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU), sitting beside the ALU in the execute stage.
- Consumes the carry/sum outputs of an XLEN-wide ripple chain of the 1-bit full-adder cell as its partial-product adder.
- Reports completion to the pipeline stall logic through a start/busy/done handshake.
- One partial product per clock, so latency is fixed and data-independent.

---
 rtl/seq_multiplier.sv | 162 ++++++++++++++++
 tb/tb_seq_multiplier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the RV32M multiply group (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to magnitudes, multiplied one bit per clock, then sign-corrected.
//
// state  | meaning
// IDLE   | waiting for start; flush blocks acceptance
// CALC   | one partial product per edge, XLEN iterations
// FIX    | sign correction, half select, done asserted
// DONE   | one-cycle done pulse, start ignored

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_MULHU = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_abs, rs2_abs;
    logic [XLEN-1:0]   addend, fa_sum;
    logic [XLEN:0]     carry;
    logic [2*XLEN-1:0] prod_fix;

    assign rs1_neg = (op != OP_MULHU) & rs1[XLEN-1];
    assign rs2_neg = ((op == OP_MUL) | (op == OP_MULH)) & rs2[XLEN-1];
    assign rs1_abs = rs1_neg ? (~rs1 + 1'b1) : rs1;
    assign rs2_abs = rs2_neg ? (~rs2 + 1'b1) : rs2;

    // Partial-product adder: acc_hi + addend, carry-out kept as bit XLEN of the sum.
    assign addend   = mplier_q[0] ? mcand_q : '0;
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < XLEN; i++) begin : g_fa
        full_adder u_fa (
            .a   (prod_q[XLEN+i]),
            .b   (addend[i]),
            .cin (carry[i]),
            .sum (fa_sum[i]),
            .cout(carry[i+1])
        );
    end

    assign prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d     = op;
                    mcand_d  = rs1_abs;
                    mplier_d = rs2_abs;
                    neg_d    = rs1_neg ^ rs2_neg;
                    prod_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    prod_d   = {carry[XLEN], fa_sum, prod_q[XLEN-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!flush) begin
                    prod_d   = prod_fix;
                    result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: fixed vectors, random ops against a 64-bit arithmetic model,
// and hand sequences for ignored start, flush, and asynchronous reset.

module tb_seq_multiplier;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    seq_multiplier #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .rs1   (rs1),
        .rs2   (rs2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = ((o != 2'b11) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = ((o == 2'b00 || o == 2'b01) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic count_done(input int n, output int cnt, output logic [31:0] last_res);
        cnt = 0;
        last_res = result;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                last_res = result;
            end
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 33);
        chk({name, " busy_cycles"}, busy_cnt, 33);
        chk({name, " busy_at_done"}, {31'b0, busy}, 0);
        chk({name, " result"}, result, exp);
        @(negedge clk);
        chk({name, " done_width"}, {31'b0, done}, 0);
    endtask

    initial begin
        int          cnt;
        logic [31:0] res;
        logic [31:0] corners[5];
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        vecs.push_back('{2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000});
        vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{2'b00, 32'd3,         32'd5,         32'd15});

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset done", {31'b0, done}, 0);
        chk("reset result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            do_op(ro, ra, rb, ref_mul(ro, ra, rb), $sformatf("rand%0d", i));
        end

        // start pulsed at E5 while busy must be dropped
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; rs1 = 32'd9; rs2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        count_done(45, cnt, res);
        chk("ignored_start done_pulses", cnt, 1);
        chk("ignored_start result", res, 32'd15);

        // flush at E10 aborts without done and keeps result
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd2; rs2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 0);
        count_done(40, cnt, res);
        chk("flush done_pulses", cnt, 0);
        chk("flush result_kept", result, 32'd15);
        do_op(2'b00, 32'd4, 32'd4, 32'd16, "after_flush");

        // flush and start together in IDLE: flush wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd6; rs2 = 32'd6;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", {31'b0, busy}, 0);
        count_done(40, cnt, res);
        chk("flush_start done_pulses", cnt, 0);
        chk("flush_start result", result, 32'd16);

        // asynchronous reset between edges mid-CALC
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'h1234_5678; rs2 = 32'h8765_4321;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst busy", {31'b0, busy}, 0);
        chk("async_rst done", {31'b0, done}, 0);
        chk("async_rst result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        count_done(40, cnt, res);
        chk("async_rst done_pulses", cnt, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'd2, 32'd1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
